// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types and helpers for the request priority encoder
package enc_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = $clog2(N_DEF);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Highest set index wins; an all-zero vector yields 0 but is never presented.
    function automatic logic [W_DEF-1:0] prio_idx(input logic [N_DEF-1:0] vec);
        logic [W_DEF-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_DEF; i++) begin
            if (vec[i]) idx = W_DEF'(i);
        end
        return idx;
    endfunction

    function automatic logic [W_DEF:0] popcount(input logic [N_DEF-1:0] vec);
        logic [W_DEF:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_DEF; i++) begin
            cnt = cnt + {{W_DEF{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mux_2x1.sv
// rtl/mux_2x1.sv - width-parameterised 2:1 multiplexer cell
module mux_2x1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/prio_enc_comb.sv
// rtl/prio_enc_comb.sv - combinational N-to-W priority encoder built as a mux chain
module prio_enc_comb
    import enc_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_code
);

    // Stage i overrides the lower stages when bit i is set, so the top bit wins.
    logic [W-1:0] w_stage [N+1];

    assign w_stage[0] = '0;

    for (genvar i = 0; i < N; i++) begin : g_chain
        mux_2x1 #(.WIDTH(W)) u_mux (
            .i_a   (w_stage[i]),
            .i_b   (W'(i)),
            .i_sel (i_vec[i]),
            .o_y   (w_stage[i+1])
        );
    end

    assign o_code = w_stage[N];

endmodule

// File: rtl/prio_enc_4x2_irq.sv
// rtl/prio_enc_4x2_irq.sv - registered priority encoder with request capture and valid/ack handshake
module prio_enc_4x2_irq
    import enc_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         ack,
    input  logic         ovf_clr,
    output logic [W-1:0] code,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic [N-1:0] ovf,
    output logic [W:0]   pend_cnt
);

    state_t       r_state;
    logic [W-1:0] r_code;
    logic         r_valid;
    logic [N-1:0] r_pending;
    logic [N-1:0] r_ovf;
    logic [W:0]   r_pend_cnt;

    logic [N-1:0] w_clr_mask;
    logic [N-1:0] w_nxt;
    logic [N-1:0] w_ovf_set;
    logic [W-1:0] w_prio;

    assign w_clr_mask = (r_valid && ack) ? (N'(1) << r_code) : '0;
    // A req on the bit being acked re-sets it, so req wins over the clear.
    assign w_nxt      = (r_pending & ~w_clr_mask) | req;
    assign w_ovf_set  = req & r_pending & ~w_clr_mask;

    prio_enc_comb #(.N(N), .W(W)) u_prio (
        .i_vec  (w_nxt),
        .o_code (w_prio)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_code     <= '0;
            r_valid    <= 1'b0;
            r_pending  <= '0;
            r_ovf      <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pending  <= w_nxt;
            r_pend_cnt <= popcount(w_nxt);
            r_ovf      <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
            case (r_state)
                IDLE: begin
                    if (w_nxt != '0) begin
                        r_state <= PRESENT;
                        r_valid <= 1'b1;
                        r_code  <= w_prio;
                    end
                end
                PRESENT: begin
                    // Without ack the presented code holds; new requests never preempt it.
                    if (ack) begin
                        if (w_nxt != '0) begin
                            r_code <= w_prio;
                        end else begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                            r_code  <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_code  <= '0;
                end
            endcase
        end
    end

    assign code     = r_code;
    assign valid    = r_valid;
    assign pending  = r_pending;
    assign ovf      = r_ovf;
    assign pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_prio_enc_4x2_irq.sv
// tb/tb_prio_enc_4x2_irq.sv - self-checking bench for prio_enc_4x2_irq
module tb_prio_enc_4x2_irq;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic       ovf_clr;
    logic [1:0] code;
    logic       valid;
    logic [3:0] pending;
    logic [3:0] ovf;
    logic [2:0] pend_cnt;

    int n_cmp;
    int n_bad;

    // Reference state: set of pending lines, presented index, overflow flags.
    bit m_pend [4];
    bit m_ovf  [4];
    int m_code;
    bit m_valid;

    prio_enc_4x2_irq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .ack      (ack),
        .ovf_clr  (ovf_clr),
        .code     (code),
        .valid    (valid),
        .pending  (pending),
        .ovf      (ovf),
        .pend_cnt (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int to_int(input bit v [4]);
        int s = 0;
        for (int b = 0; b < 4; b++) s += v[b] ? (1 << b) : 0;
        return s;
    endfunction

    function automatic int count_of(input bit v [4]);
        int s = 0;
        for (int b = 0; b < 4; b++) s += v[b] ? 1 : 0;
        return s;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic a, input logic oc, input logic rn);
        bit nxt [4];
        bit served [4];
        int top;
        if (!rn) begin
            for (int b = 0; b < 4; b++) begin m_pend[b] = 0; m_ovf[b] = 0; end
            m_code = 0; m_valid = 0;
            return;
        end
        for (int b = 0; b < 4; b++) served[b] = m_valid && a && (m_code == b);
        for (int b = 0; b < 4; b++) begin
            nxt[b] = (m_pend[b] && !served[b]) || r[b];
            m_ovf[b] = (m_ovf[b] && !oc) || (r[b] && m_pend[b] && !served[b]);
        end
        top = -1;
        for (int b = 3; b >= 0; b--) if (nxt[b] && top < 0) top = b;
        if (!m_valid || a) begin
            m_valid = (top >= 0);
            m_code  = (top >= 0) ? top : 0;
        end
        m_pend = nxt;
    endtask

    task automatic cycle(input logic [3:0] r, input logic a, input logic oc, input logic rn);
        req = r; ack = a; ovf_clr = oc; rst_n = rn;
        @(posedge clk);
        model_step(r, a, oc, rn);
        #1;
        check("code",     int'(code),     m_code);
        check("valid",    int'(valid),    int'(m_valid));
        check("pending",  int'(pending),  to_int(m_pend));
        check("ovf",      int'(ovf),      to_int(m_ovf));
        check("pend_cnt", int'(pend_cnt), count_of(m_pend));
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        m_code = 0; m_valid = 0;
        for (int b = 0; b < 4; b++) begin m_pend[b] = 0; m_ovf[b] = 0; end
        req = '0; ack = 0; ovf_clr = 0; rst_n = 0;
        #2;

        // Reset with all requests high
        cycle(4'b1111, 0, 0, 0);
        cycle(4'b1111, 0, 0, 0);
        check("rst_pending", int'(pending), 0);
        check("rst_valid",   int'(valid),   0);
        repeat (3) cycle(4'b0000, 0, 0, 1);
        check("post_rst_cnt", int'(pend_cnt), 0);

        // Single request held without ack
        cycle(4'b0100, 0, 0, 1);
        check("single_code", int'(code), 2);
        repeat (10) cycle(4'b0000, 0, 0, 1);
        check("single_hold", int'(code), 2);
        cycle(4'b0000, 1, 0, 1);
        check("single_done", int'(valid), 0);

        // Priority drain with ack held
        cycle(4'b1011, 0, 0, 1);
        check("drain_c3", int'(code), 3);
        check("drain_n3", int'(pend_cnt), 3);
        cycle(4'b0000, 1, 0, 1);
        check("drain_c1", int'(code), 1);
        check("drain_n2", int'(pend_cnt), 2);
        cycle(4'b0000, 1, 0, 1);
        check("drain_c0", int'(code), 0);
        check("drain_v",  int'(valid), 1);
        cycle(4'b0000, 1, 0, 1);
        check("drain_end", int'(valid), 0);
        check("drain_n0",  int'(pend_cnt), 0);

        // No preemption
        cycle(4'b0010, 0, 0, 1);
        cycle(4'b1000, 0, 0, 1);
        check("nopre_code", int'(code), 1);
        check("nopre_pend", int'(pending), 4'b1010);
        cycle(4'b0000, 1, 0, 1);
        check("nopre_next", int'(code), 3);
        cycle(4'b0000, 1, 0, 1);

        // Ack and req on the same bit
        cycle(4'b0100, 0, 0, 1);
        cycle(4'b0100, 1, 0, 1);
        check("coll_pend", int'(pending[2]), 1);
        check("coll_code", int'(code), 2);
        check("coll_ovf",  int'(ovf), 0);
        cycle(4'b0000, 1, 0, 1);

        // Overflow set, set-wins, clear
        cycle(4'b0001, 0, 0, 1);
        cycle(4'b0001, 0, 0, 1);
        check("ovf_set", int'(ovf), 4'b0001);
        cycle(4'b0001, 0, 1, 1);
        check("ovf_setwins", int'(ovf), 4'b0001);
        cycle(4'b0000, 0, 1, 1);
        check("ovf_clr", int'(ovf), 0);
        cycle(4'b0000, 1, 0, 1);

        // Random traffic, occasional mid-handshake reset
        for (int i = 0; i < 500; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            cycle(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 49) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
